button_conditioner: RTL and testbench

Per-button input conditioner for the alarm clock front panel. It sits directly upstream of the level-driven toggle FSMs, which consume its `level` outputs. Each raw, asynchronous, bouncing push-button is synchronised and debounced. The block also produces single-cycle press and release pulses, plus a hold-to-auto-repeat pulse train for the time-setting buttons.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/button_channel.sv | 147 ++++++++++++++
 rtl/button_conditioner.sv | 36 +++
 tb/tb_button_conditioner.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared constants for the alarm clock front panel: hold-FSM state encoding,
// default button timing derived from the panel clock, and a counter-width helper.
package alarm_pkg;

    localparam int CLK_HZ = 50_000_000;

    // 10 ms debounce, 1 s hold before auto-repeat, 200 ms repeat period
    localparam int DEF_STABLE_CYCLES = CLK_HZ / 100;
    localparam int DEF_HOLD_CYCLES   = CLK_HZ;
    localparam int DEF_REPEAT_CYCLES = CLK_HZ / 5;

    typedef logic [1:0] hold_state_t;

    localparam hold_state_t ST_IDLE = 2'b00;
    localparam hold_state_t ST_HELD = 2'b01;
    localparam hold_state_t ST_RPT  = 2'b10;

    function automatic int cnt_width(input int n);
        int w;
        if (n > 1) begin
            w = $clog2(n);
        end else begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button lane: two-flop synchroniser, stability-count debounce filter,
// edge pulses and a hold/auto-repeat FSM. All outputs are registered.
module button_channel
    import alarm_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic press_pulse,
    output logic rel_pulse,
    output logic rpt_pulse
);

    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = cnt_width(STABLE_CYCLES);
    localparam int HW   = cnt_width(HMAX + 1);

    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO    = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_CYCLES);
    localparam logic [HW-1:0] HCNT_ZERO   = {HW{1'b0}};
    localparam logic [HW-1:0] HCNT_ONE    = HW'(1);

    logic          s1_r;
    logic          s2_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          accept_s;
    logic          lvl_nxt_s;
    logic          rise_s;
    logic          fall_s;
    hold_state_t   state_r;
    hold_state_t   state_nxt_s;
    logic [HW-1:0] hcnt_r;
    logic [HW-1:0] hcnt_nxt_s;
    logic          rpt_nxt_s;

    // Debounce: accept s2 once it has disagreed with level for STABLE_CYCLES edges
    always_comb begin
        cnt_nxt_s = cnt_r;
        accept_s  = 1'b0;
        if (s2_r == level) begin
            cnt_nxt_s = CNT_ZERO;
        end else if (cnt_r == STABLE_LAST) begin
            accept_s  = 1'b1;
            cnt_nxt_s = CNT_ZERO;
        end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
        end
    end

    // Next filtered level and its edges, shared by the pulse outputs and the hold FSM
    always_comb begin
        if (accept_s) begin
            lvl_nxt_s = s2_r;
        end else begin
            lvl_nxt_s = level;
        end
        rise_s = accept_s & s2_r;
        fall_s = accept_s & ~s2_r;
    end

    // Hold FSM looks at the next level so a release on a repeat edge suppresses the repeat
    always_comb begin
        state_nxt_s = state_r;
        hcnt_nxt_s  = hcnt_r;
        rpt_nxt_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_HELD;
                    hcnt_nxt_s  = HCNT_ONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                    hcnt_nxt_s  = HCNT_ZERO;
                end
            end
            ST_HELD: begin
                if (!lvl_nxt_s) begin
                    state_nxt_s = ST_IDLE;
                    hcnt_nxt_s  = HCNT_ZERO;
                end else if (hcnt_r == HOLD_LAST) begin
                    rpt_nxt_s   = 1'b1;
                    state_nxt_s = ST_RPT;
                    hcnt_nxt_s  = HCNT_ONE;
                end else begin
                    hcnt_nxt_s  = hcnt_r + HCNT_ONE;
                end
            end
            ST_RPT: begin
                if (!lvl_nxt_s) begin
                    state_nxt_s = ST_IDLE;
                    hcnt_nxt_s  = HCNT_ZERO;
                end else if (hcnt_r == REPEAT_LAST) begin
                    rpt_nxt_s   = 1'b1;
                    hcnt_nxt_s  = HCNT_ONE;
                end else begin
                    hcnt_nxt_s  = hcnt_r + HCNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                hcnt_nxt_s  = HCNT_ZERO;
            end
        endcase
    end

    // Synchroniser, filter state and edge pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r        <= 1'b0;
            s2_r        <= 1'b0;
            cnt_r       <= CNT_ZERO;
            level       <= 1'b0;
            press_pulse <= 1'b0;
            rel_pulse   <= 1'b0;
        end else begin
            s1_r        <= btn_raw;
            s2_r        <= s1_r;
            cnt_r       <= cnt_nxt_s;
            level       <= lvl_nxt_s;
            press_pulse <= rise_s;
            rel_pulse   <= fall_s;
        end
    end

    // Hold FSM state, hold/repeat counter and repeat pulse register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            hcnt_r    <= HCNT_ZERO;
            rpt_pulse <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            hcnt_r    <= hcnt_nxt_s;
            rpt_pulse <= rpt_nxt_s;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: N_BTN independent button_channel lanes
// producing debounced levels plus press, release and auto-repeat pulses.
module button_conditioner
    import alarm_pkg::*;
#(
    parameter int N_BTN         = 4,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] level,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] rel_pulse,
    output logic [N_BTN-1:0] rpt_pulse
);

    for (genvar g = 0; g < N_BTN; g++) begin : g_ch
        button_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .HOLD_CYCLES   (HOLD_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .btn_raw     (btn_raw[g]),
            .level       (level[g]),
            .press_pulse (press_pulse[g]),
            .rel_pulse   (rel_pulse[g]),
            .rpt_pulse   (rpt_pulse[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomised and directed bench for button_conditioner; a window/arithmetic
// reference model is compared against every output on every clock edge.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int SC = 4;
    localparam int HC = 10;
    localparam int RC = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] level;
    logic [NB-1:0] press_pulse;
    logic [NB-1:0] rel_pulse;
    logic [NB-1:0] rpt_pulse;

    always #5 clk = ~clk;

    button_conditioner #(
        .N_BTN         (NB),
        .STABLE_CYCLES (SC),
        .HOLD_CYCLES   (HC),
        .REPEAT_CYCLES (RC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .level       (level),
        .press_pulse (press_pulse),
        .rel_pulse   (rel_pulse),
        .rpt_pulse   (rpt_pulse)
    );

    int vectors     = 0;
    int miscompares = 0;
    int edge_n      = 0;

    // reference model state
    bit m_level [NB];
    bit m_press [NB];
    bit m_rel   [NB];
    bit m_rpt   [NB];
    int rise_e  [NB];
    int press_cnt[NB];
    int rel_cnt [NB];
    int rpt_cnt [NB];
    int last_press_edge[NB];
    int last_rel_edge  [NB];
    bit samp_q [NB][$];
    bit win_q  [NB][$];
    int rpt_edges[NB][$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s @edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
        end
    endtask

    // s2 seen at an edge is the raw value sampled two edges earlier; level flips once the
    // last SC s2 values all disagree with it; repeats fall at HC, HC+RC, ... after the rise
    task automatic model_step();
        bit s2pre;
        bit all_diff;
        int d;
        edge_n++;
        for (int c = 0; c < NB; c++) begin
            m_press[c] = 1'b0;
            m_rel[c]   = 1'b0;
            m_rpt[c]   = 1'b0;
            if (rst) begin
                samp_q[c].delete();
                win_q[c].delete();
                m_level[c] = 1'b0;
                rise_e[c]  = -1;
            end else begin
                s2pre = (samp_q[c].size() >= 2) ? samp_q[c][samp_q[c].size()-2] : 1'b0;
                samp_q[c].push_back(btn_raw[c]);
                if (samp_q[c].size() > 2) void'(samp_q[c].pop_front());
                win_q[c].push_back(s2pre);
                if (win_q[c].size() > SC) void'(win_q[c].pop_front());
                all_diff = (win_q[c].size() == SC);
                for (int i = 0; i < win_q[c].size(); i++)
                    if (win_q[c][i] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c] = !m_level[c];
                    if (m_level[c]) begin
                        m_press[c] = 1'b1;
                        rise_e[c] = edge_n;
                        press_cnt[c]++;
                        last_press_edge[c] = edge_n;
                        rpt_edges[c].delete();
                    end else begin
                        m_rel[c] = 1'b1;
                        rise_e[c] = -1;
                        rel_cnt[c]++;
                        last_rel_edge[c] = edge_n;
                    end
                end else if (m_level[c]) begin
                    d = edge_n - rise_e[c];
                    if (d == HC || (d > HC && ((d - HC) % RC) == 0)) begin
                        m_rpt[c] = 1'b1;
                        rpt_cnt[c]++;
                        rpt_edges[c].push_back(edge_n);
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < NB; c++) begin
            chk($sformatf("level[%0d]", c), int'(level[c]), int'(m_level[c]));
            chk($sformatf("press_pulse[%0d]", c), int'(press_pulse[c]), int'(m_press[c]));
            chk($sformatf("rel_pulse[%0d]", c), int'(rel_pulse[c]), int'(m_rel[c]));
            chk($sformatf("rpt_pulse[%0d]", c), int'(rpt_pulse[c]), int'(m_rpt[c]));
        end
    endtask

    // model advances on each rising edge, outputs are compared 1 time unit later
    initial begin
        for (int c = 0; c < NB; c++) rise_e[c] = -1;
        forever begin
            @(posedge clk);
            model_step();
            #1;
            compare_all();
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int e0, e_rise, p0, r0, q0, rr;
        int rem[NB];
        rst     = 1'b1;
        btn_raw = '0;
        cyc(3);
        chk("reset_level", int'(level), 0);
        chk("reset_pulses", int'(press_pulse | rel_pulse | rpt_pulse), 0);
        rst = 1'b0;
        cyc(3);

        // clean press on channel 0, then a long hold
        btn_raw[0] = 1'b1;
        e0 = edge_n + 1;
        cyc(8);
        chk("clean_press_latency", last_press_edge[0] - e0, 5);
        chk("clean_level0", int'(level[0]), 1);
        chk("clean_ch1_quiet", press_cnt[1], 0);
        e_rise = last_press_edge[0];
        cyc(e_rise + 17 - edge_n);
        chk("hold_rpt_count", rpt_edges[0].size(), 3);
        if (rpt_edges[0].size() >= 3) begin
            chk("hold_rpt_first", rpt_edges[0][0] - e_rise, 10);
            chk("hold_rpt_second", rpt_edges[0][1] - e_rise, 13);
            chk("hold_rpt_third", rpt_edges[0][2] - e_rise, 16);
        end
        r0 = rel_cnt[0];
        btn_raw[0] = 1'b0;
        cyc(12);
        chk("release_one_rel", rel_cnt[0] - r0, 1);
        chk("release_total_rpts", rpt_edges[0].size(), 5);
        if (rpt_edges[0].size() > 0)
            chk("release_no_late_rpt", int'(rpt_edges[0][rpt_edges[0].size()-1] > last_rel_edge[0]), 0);

        // glitch of three cycles
        p0 = press_cnt[0];
        q0 = rpt_cnt[0];
        btn_raw[0] = 1'b1;
        cyc(3);
        btn_raw[0] = 1'b0;
        cyc(12);
        chk("glitch_no_press", press_cnt[0] - p0, 0);
        chk("glitch_no_rpt", rpt_cnt[0] - q0, 0);

        // bounce every 2 cycles, then settle high
        p0 = press_cnt[0];
        r0 = rel_cnt[0];
        for (int i = 0; i < 10; i++) begin
            btn_raw[0] = ~btn_raw[0];
            cyc(2);
        end
        btn_raw[0] = 1'b1;
        e0 = edge_n + 1;
        cyc(10);
        chk("bounce_one_press", press_cnt[0] - p0, 1);
        chk("bounce_press_latency", last_press_edge[0] - e0, 5);
        chk("bounce_no_rel", rel_cnt[0] - r0, 0);
        btn_raw[0] = 1'b0;
        cyc(12);

        // reset in the middle of a hold with the button still down
        btn_raw[0] = 1'b1;
        cyc(7);
        e_rise = last_press_edge[0];
        cyc(e_rise + 6 - edge_n);
        rst = 1'b1;
        cyc(1);
        chk("midhold_rst_level", int'(level[0]), 0);
        chk("midhold_rst_pulses", int'(press_pulse[0] | rel_pulse[0] | rpt_pulse[0]), 0);
        cyc(1);
        rst = 1'b0;
        rr = edge_n;
        cyc(20);
        chk("post_rst_press", last_press_edge[0] - rr, 6);
        chk("post_rst_rpt_seen", int'(rpt_edges[0].size() > 0), 1);
        if (rpt_edges[0].size() > 0)
            chk("post_rst_first_rpt", rpt_edges[0][0] - last_press_edge[0], 10);
        btn_raw[0] = 1'b0;
        cyc(12);

        // independence: channels pressed two cycles apart
        btn_raw[0] = 1'b1;
        cyc(2);
        btn_raw[1] = 1'b1;
        cyc(25);
        chk("indep_press_offset", last_press_edge[1] - last_press_edge[0], 2);
        chk("indep_rpt_seen", int'(rpt_edges[0].size() > 0 && rpt_edges[1].size() > 0), 1);
        if (rpt_edges[0].size() > 0 && rpt_edges[1].size() > 0)
            chk("indep_rpt_offset", rpt_edges[1][0] - rpt_edges[0][0], 2);
        btn_raw = '0;
        cyc(12);

        // random runs of varying length, with occasional resets
        for (int c = 0; c < NB; c++) rem[c] = 0;
        for (int n = 0; n < 4000; n++) begin
            for (int c = 0; c < NB; c++) begin
                if (rem[c] == 0) begin
                    btn_raw[c] = ~btn_raw[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40)
                                                          : $urandom_range(1, 7);
                end else begin
                    rem[c]--;
                end
            end
            rst = ($urandom_range(0, 499) == 0);
            cyc(1);
        end
        rst = 1'b0;
        btn_raw = '0;
        cyc(15);
        chk("final_level", int'(level), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
